// File: rtl/counter_sequencer_pkg.sv
// Shared encodings and default parameters for the counter sequencer slice.
package counter_seq_pkg;

  localparam int unsigned W_DEF          = 4;
  localparam int unsigned SC_W_DEF       = 8;
  localparam int unsigned DEB_CYCLES_DEF = 16;
  localparam int unsigned TICK_DIV_DEF   = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_t;

endpackage

// File: rtl/counter_sequencer_if.sv
// Button, counter-feedback and counter-control signals between the sequencer and its board.
interface counter_sequencer_if #(
  parameter int unsigned W    = counter_seq_pkg::W_DEF,
  parameter int unsigned SC_W = counter_seq_pkg::SC_W_DEF
);

  logic            key_step_n;
  logic            key_load_n;
  logic            key_run_n;
  logic [W-1:0]    load_val;
  logic [W-1:0]    term_val;
  logic [W-1:0]    cnt_q;
  logic            cnt_load_n;
  logic [W-1:0]    cnt_data;
  logic            cnt_step;
  logic            tc;
  logic [1:0]      state;
  logic [SC_W-1:0] step_count;

  modport master (
    output key_step_n, key_load_n, key_run_n, load_val, term_val, cnt_q,
    input  cnt_load_n, cnt_data, cnt_step, tc, state, step_count
  );

  modport slave (
    input  key_step_n, key_load_n, key_run_n, load_val, term_val, cnt_q,
    output cnt_load_n, cnt_data, cnt_step, tc, state, step_count
  );

endinterface

// File: rtl/counter_sequencer_key_debounce.sv
// Synchronizes and debounces one active-low pushbutton; pulses press on each accepted press.
module key_debounce
  import counter_seq_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int unsigned CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == CNT_W'(DEB_CYCLES - 1));

  // Level flips only after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (w_last) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
        r_press <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/counter_sequencer.sv
// Controller for the DE2 4-bit JK counter: debounced buttons, load/step strobes and a
// divided auto-run that halts when the counter reaches a programmable terminal value.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int unsigned W          = W_DEF,
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int unsigned TICK_DIV   = TICK_DIV_DEF,
  parameter int unsigned SC_W       = SC_W_DEF
) (
  input logic                clk,
  input logic                rst_n,
  counter_sequencer_if.slave bus
);

  localparam int unsigned     DIV_W  = $clog2(TICK_DIV);
  localparam logic [SC_W-1:0] SC_MAX = '1;

  logic [2:0] w_unused_lvl;
  logic       w_step_ev;
  logic       w_load_ev;
  logic       w_run_ev;
  logic       w_tick;

  state_t           r_state;
  logic             r_load_n;
  logic             r_step;
  logic             r_tc;
  logic [W-1:0]     r_data;
  logic [SC_W-1:0]  r_sc;
  logic [DIV_W-1:0] r_div;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
    .clk(clk), .rst_n(rst_n), .key_n(bus.key_step_n), .level(w_unused_lvl[0]), .press(w_step_ev)
  );
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_load (
    .clk(clk), .rst_n(rst_n), .key_n(bus.key_load_n), .level(w_unused_lvl[1]), .press(w_load_ev)
  );
  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
    .clk(clk), .rst_n(rst_n), .key_n(bus.key_run_n), .level(w_unused_lvl[2]), .press(w_run_ev)
  );

  assign w_tick = (r_div == DIV_W'(TICK_DIV - 1));

  // Load preempts everything outside LOAD; within a state run beats step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_load_n <= 1'b1;
      r_step   <= 1'b0;
      r_tc     <= 1'b0;
      r_data   <= '0;
      r_sc     <= '0;
      r_div    <= '0;
    end else begin
      r_load_n <= 1'b1;
      r_step   <= 1'b0;
      r_tc     <= 1'b0;
      if (r_step && (r_sc != SC_MAX)) begin
        r_sc <= r_sc + SC_W'(1);
      end

      if (w_load_ev && (r_state != ST_LOAD)) begin
        r_state  <= ST_LOAD;
        r_load_n <= 1'b0;
        r_data   <= bus.load_val;
        r_sc     <= '0;
        r_div    <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_run_ev) begin
              r_state <= ST_RUN;
              r_div   <= '0;
            end else if (w_step_ev) begin
              r_step <= 1'b1;
            end
          end
          ST_LOAD: r_state <= ST_IDLE;
          ST_RUN: begin
            if (w_run_ev) begin
              r_state <= ST_IDLE;
            end else begin
              r_div <= w_tick ? '0 : r_div + DIV_W'(1);
              if (w_tick) begin
                if (bus.cnt_q == bus.term_val) begin
                  r_state <= ST_HALT;
                  r_tc    <= 1'b1;
                end else begin
                  r_step <= 1'b1;
                end
              end
            end
          end
          ST_HALT: begin
            if (w_run_ev) begin
              r_state <= ST_IDLE;
            end else begin
              r_tc <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.cnt_load_n = r_load_n;
  assign bus.cnt_data   = r_data;
  assign bus.cnt_step   = r_step;
  assign bus.tc         = r_tc;
  assign bus.state      = 2'(r_state);
  assign bus.step_count = r_sc;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: directed scenarios plus random button traffic against a behavioural model.
`timescale 1ns/1ps
module tb_counter_sequencer;

  localparam int unsigned W    = 4;
  localparam int unsigned SC_W = 8;
  localparam int unsigned DEB  = 4;
  localparam int unsigned TD   = 4;
  localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_HALT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic k_step = 1'b1, k_load = 1'b1, k_run = 1'b1;
  logic [W-1:0] lv = '0, tv = '0;
  logic [W-1:0] r_cnt_q = '0;

  int n_vec = 0, n_mis = 0, n_print = 0;
  int n_load_pulses = 0, n_step_pulses = 0;

  // Behavioural model state (post-edge values of every DUT output).
  bit m_valid = 1'b0;
  bit m_load_n = 1'b1, m_step = 1'b0, m_tc = 1'b0;
  int m_state = 0, m_data = 0, m_sc = 0, m_div = 0, m_cnt = 0;
  bit m_pipe [3][2];
  bit m_lvl [3];
  int m_run [3];
  bit m_press [3];

  initial forever #5 clk = ~clk;

  counter_sequencer_if #(.W(W), .SC_W(SC_W)) bus ();

  counter_sequencer #(.W(W), .DEB_CYCLES(DEB), .TICK_DIV(TD), .SC_W(SC_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  assign bus.key_step_n = k_step;
  assign bus.key_load_n = k_load;
  assign bus.key_run_n  = k_run;
  assign bus.load_val   = lv;
  assign bus.term_val   = tv;
  assign bus.cnt_q      = r_cnt_q;

  // The 4-bit counter on the board, driven by the DUT.
  always @(posedge clk) begin
    if (bus.cnt_load_n == 1'b0) r_cnt_q <= bus.cnt_data;
    else if (bus.cnt_step == 1'b1) r_cnt_q <= r_cnt_q + 4'd1;
  end

  initial forever begin : model
    bit raw [3];
    bit ev_s, ev_l, ev_r, do_load, tick, samp;
    int old_cnt;
    @(posedge clk);
    raw[0] = k_step; raw[1] = k_load; raw[2] = k_run;
    old_cnt = m_cnt;
    if (m_valid) begin
      if (!m_load_n) m_cnt = m_data;
      else if (m_step) m_cnt = (m_cnt + 1) % 16;
    end
    if (!rst_n) begin
      m_valid = 1'b1; m_state = M_IDLE; m_load_n = 1'b1; m_step = 1'b0; m_tc = 1'b0;
      m_data = 0; m_sc = 0; m_div = 0;
      for (int k = 0; k < 3; k++) begin
        m_pipe[k][0] = 1'b1; m_pipe[k][1] = 1'b1; m_lvl[k] = 1'b1; m_run[k] = 0; m_press[k] = 1'b0;
      end
    end else if (m_valid) begin
      ev_l = m_press[1];
      ev_r = m_press[2] && !ev_l;
      ev_s = m_press[0] && !ev_l && !ev_r;
      if (m_step) m_sc = (m_sc == 255) ? 255 : m_sc + 1;
      m_step = 1'b0; m_load_n = 1'b1; do_load = 1'b0;
      case (m_state)
        M_IDLE: begin
          if (ev_l) do_load = 1'b1;
          else if (ev_r) begin m_state = M_RUN; m_div = 0; end
          else if (ev_s) m_step = 1'b1;
        end
        M_LOAD: m_state = M_IDLE;
        M_RUN: begin
          tick = (m_div == TD - 1);
          if (ev_l) do_load = 1'b1;
          else if (ev_r) m_state = M_IDLE;
          else begin
            m_div = (m_div + 1) % TD;
            if (tick) begin
              if (old_cnt == int'(tv)) m_state = M_HALT;
              else m_step = 1'b1;
            end
          end
        end
        default: begin
          if (ev_l) do_load = 1'b1;
          else if (ev_r) m_state = M_IDLE;
        end
      endcase
      if (do_load) begin
        m_state = M_LOAD; m_load_n = 1'b0; m_data = int'(lv); m_sc = 0; m_div = 0;
      end
      m_tc = (m_state == M_HALT);
      for (int k = 0; k < 3; k++) begin
        samp = m_pipe[k][1];
        m_pipe[k][1] = m_pipe[k][0];
        m_pipe[k][0] = raw[k];
        m_press[k] = 1'b0;
        if (samp == m_lvl[k]) m_run[k] = 0;
        else begin
          m_run[k] = m_run[k] + 1;
          if (m_run[k] == DEB) begin
            m_lvl[k] = samp; m_run[k] = 0; m_press[k] = !samp;
          end
        end
      end
    end
  end

  initial forever begin : compare
    @(negedge clk);
    if (bus.cnt_load_n === 1'b0) n_load_pulses++;
    if (bus.cnt_step === 1'b1) n_step_pulses++;
    if (m_valid) begin
      n_vec++;
      if (bus.state !== 2'(m_state) || bus.cnt_load_n !== m_load_n || bus.cnt_step !== m_step ||
          bus.cnt_data !== 4'(m_data) || bus.tc !== m_tc || bus.step_count !== 8'(m_sc) ||
          bus.cnt_q !== 4'(m_cnt)) begin
        n_mis++;
        if (n_print < 20) begin
          n_print++;
          $display("FAIL model t=%0t: dut st=%0d ld_n=%b stp=%b dat=%0d tc=%b sc=%0d q=%0d, required st=%0d ld_n=%b stp=%b dat=%0d tc=%b sc=%0d q=%0d",
                   $time, bus.state, bus.cnt_load_n, bus.cnt_step, bus.cnt_data, bus.tc, bus.step_count, bus.cnt_q,
                   m_state, m_load_n, m_step, m_data, m_tc, m_sc, m_cnt);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0: k_step = v;
      1: k_load = v;
      default: k_run = v;
    endcase
  endtask

  task automatic press(input int k, input int hold, input int bounce);
    for (int b = 0; b < bounce; b++) begin
      set_key(k, 1'b0); cyc($urandom_range(1, 3));
      set_key(k, 1'b1); cyc($urandom_range(1, 3));
    end
    set_key(k, 1'b0); cyc(hold);
    set_key(k, 1'b1); cyc(DEB + 4);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int lp0, sp0, t, prev, r, mask, hold;

    // 1: reset with all keys held
    k_step = 1'b0; k_load = 1'b0; k_run = 1'b0;
    rst_n = 1'b0; cyc(3);
    chk("rst state", 32'(bus.state), 0);
    chk("rst load_n", 32'(bus.cnt_load_n), 1);
    chk("rst step", 32'(bus.cnt_step), 0);
    chk("rst data", 32'(bus.cnt_data), 0);
    chk("rst tc", 32'(bus.tc), 0);
    chk("rst step_count", 32'(bus.step_count), 0);
    lp0 = n_load_pulses; sp0 = n_step_pulses;
    rst_n = 1'b1;
    cyc(6);
    chk("t1 load_n before event", 32'(bus.cnt_load_n), 1);
    cyc(1);
    chk("t1 load_n strobe", 32'(bus.cnt_load_n), 0);
    chk("t1 state LOAD", 32'(bus.state), 1);
    k_step = 1'b1; k_load = 1'b1; k_run = 1'b1;
    cyc(12);
    chk("t1 load events", 32'(n_load_pulses - lp0), 1);
    chk("t1 step events", 32'(n_step_pulses - sp0), 0);
    chk("t1 state", 32'(bus.state), 0);

    // 2: load 9
    lv = 4'd9; lp0 = n_load_pulses;
    press(1, 12, 0);
    chk("t2 load events", 32'(n_load_pulses - lp0), 1);
    chk("t2 cnt_data", 32'(bus.cnt_data), 9);
    chk("t2 cnt_q", 32'(bus.cnt_q), 9);
    chk("t2 step_count", 32'(bus.step_count), 0);
    chk("t2 state", 32'(bus.state), 0);

    // 3: bouncy step press
    sp0 = n_step_pulses;
    press(0, 10, 3);
    chk("t3 step events", 32'(n_step_pulses - sp0), 1);
    chk("t3 cnt_q", 32'(bus.cnt_q), 10);
    chk("t3 step_count", 32'(bus.step_count), 1);

    // 4: run from 3 to terminal 7
    lv = 4'd3; press(1, 6, 0);
    tv = 4'd7; sp0 = n_step_pulses;
    press(2, 6, 0);
    t = 0;
    while (bus.tc !== 1'b1 && t < 100) begin cyc(1); t++; end
    chk("t4 tc", 32'(bus.tc), 1);
    chk("t4 state", 32'(bus.state), 3);
    chk("t4 step_count", 32'(bus.step_count), 4);
    chk("t4 cnt_q", 32'(bus.cnt_q), 7);
    cyc(12);
    chk("t4 steps total", 32'(n_step_pulses - sp0), 4);
    chk("t4 still halted", 32'(bus.state), 3);

    // 5: load and run pressed together while running
    press(2, 6, 0);
    chk("t5 paused state", 32'(bus.state), 0);
    chk("t5 tc dropped", 32'(bus.tc), 0);
    lv = 4'd0; tv = 4'd6;
    k_run = 1'b0; cyc(6); k_run = 1'b1; cyc(DEB + 6);
    chk("t5 running", 32'(bus.state), 2);
    lp0 = n_load_pulses;
    k_load = 1'b0; k_run = 1'b0;
    t = 0; prev = 32'(bus.state);
    while (bus.cnt_load_n !== 1'b0 && t < 20) begin prev = 32'(bus.state); cyc(1); t++; end
    chk("t5 state before load", 32'(prev), 2);
    chk("t5 state LOAD", 32'(bus.state), 1);
    cyc(1);
    chk("t5 state after load", 32'(bus.state), 0);
    k_load = 1'b1; k_run = 1'b1; cyc(12);
    chk("t5 load events", 32'(n_load_pulses - lp0), 1);

    // 6: reset just before a tick
    tv = 4'd15;
    press(2, 6, 0);
    t = 0;
    while (!(m_state == M_RUN && m_div == TD - 1) && t < 30) begin cyc(1); t++; end
    chk("t6 reached pre-tick", 32'(t < 30), 1);
    rst_n = 1'b0; cyc(1);
    sp0 = n_step_pulses;
    chk("t6 no step", 32'(bus.cnt_step), 0);
    chk("t6 state", 32'(bus.state), 0);
    chk("t6 step_count", 32'(bus.step_count), 0);
    chk("t6 cnt_data", 32'(bus.cnt_data), 0);
    rst_n = 1'b1; cyc(8);
    chk("t6 no later step", 32'(n_step_pulses - sp0), 0);

    // step_count saturation
    sp0 = n_step_pulses;
    for (int i = 0; i < 258; i++) begin
      k_step = 1'b0; cyc(6); k_step = 1'b1; cyc(7);
    end
    chk("sat steps", 32'(n_step_pulses - sp0), 258);
    chk("sat step_count", 32'(bus.step_count), 255);

    // random button traffic
    for (int it = 0; it < 80; it++) begin
      r = $urandom_range(0, 99);
      if (r < 6) begin
        rst_n = 1'b0; cyc($urandom_range(1, 2)); rst_n = 1'b1;
      end else begin
        if ($urandom_range(0, 2) == 0) lv = 4'($urandom);
        if ($urandom_range(0, 2) == 0) tv = 4'($urandom);
        else if ($urandom_range(0, 3) == 0) tv = r_cnt_q + 4'($urandom_range(0, 3));
        mask = $urandom_range(1, 7);
        hold = $urandom_range(1, 12);
        if (mask[0]) k_step = 1'b0;
        if (mask[1]) k_load = 1'b0;
        if (mask[2]) k_run = 1'b0;
        cyc(hold);
        k_step = 1'b1; k_load = 1'b1; k_run = 1'b1;
      end
      cyc($urandom_range(0, 16) + ((r % 3 == 0) ? 20 : 0));
    end

    cyc(10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Controller for the 4-bit loadable JK-flip-flop counter on the DE2 board.
- Debounces the step, load and run pushbuttons (active-low KEY inputs).
- Drives the counter's active-low load strobe, its load data and a one-cycle step enable.
- In run mode it auto-steps at a divided rate until the counter reaches a programmable terminal value. cnt_q is fed back from the counter for terminal detection.

Parameters:
- W, 4: counter width.
- DEB_CYCLES, 16: consecutive stable samples needed to accept a button level change (board build uses 1000000).
- TICK_DIV, 8: clock cycles between auto-steps in RUN; legal range >= 2.
- SC_W, 8: width of the saturating step_count.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- key_step_n  in  1  raw step pushbutton, 0 = pressed, asynchronous.
- key_load_n  in  1  raw load pushbutton, 0 = pressed, asynchronous.
- key_run_n  in  1  raw run/pause pushbutton, 0 = pressed, asynchronous.
- load_val  in  W  value to load into the counter.
- term_val  in  W  terminal value for RUN.
- cnt_q  in  W  current counter value.
- cnt_load_n  out  1  load strobe to counter, active-low, one cycle.
- cnt_data  out  W  load data, held stable until the next load.
- cnt_step  out  1  one-cycle step enable to counter.
- tc  out  1  high while in HALT.
- state  out  2  FSM state: IDLE=0, LOAD=1, RUN=2, HALT=3.
- step_count  out  SC_W  steps issued since the last load, saturating.

Behaviour:
- Reset (rst_n sampled low at a rising clk edge) forces:
  - cnt_load_n=1, cnt_step=0, cnt_data=0, tc=0, state=IDLE, step_count=0;
  - debounced levels=1 (released), synchronizers=1, debounce counters=0, divider=0.
- Reset mid-operation abandons any pending load or step; no pulse is emitted on the reset cycle.
- Input conditioning, per key:
  - 2-flop synchronizer, then a stable counter;
  - the debounced level changes only after DEB_CYCLES consecutive samples that differ from the current debounced level; any matching sample clears the counter;
  - press event = one-cycle pulse on a debounced 1->0 transition; release produces no event;
  - latency from a clean raw edge to the press pulse is DEB_CYCLES+2 cycles;
  - a held button gives exactly one event.
- Same-cycle event priority: load > run > step. Lower-priority events in that cycle are discarded.
- IDLE:
  - load_ev -> LOAD.
  - run_ev -> RUN, divider cleared.
  - step_ev -> cnt_step=1 for one cycle (the cycle after the event); stay in IDLE.
- LOAD:
  - one-cycle state; cnt_load_n=0 exactly this cycle;
  - cnt_data takes load_val on entry;
  - step_count cleared; divider cleared;
  - next state IDLE unconditionally; events arriving during LOAD are dropped.
- RUN:
  - divider counts 0..TICK_DIV-1 and wraps; a tick occurs when divider==TICK_DIV-1;
  - at a tick: if cnt_q==term_val -> HALT with no step; else cnt_step=1 next cycle;
  - first step issues TICK_DIV cycles after RUN entry;
  - load_ev -> LOAD; run_ev -> IDLE (pause, divider held); step_ev ignored;
  - if load_ev or run_ev coincides with a tick, the event wins and no step is issued.
- HALT:
  - tc=1; step_ev ignored;
  - load_ev -> LOAD; run_ev -> IDLE, tc drops.
- step_count increments by 1 on every cycle where cnt_step=1 and saturates at 2^SC_W-1 (no wrap).
- cnt_step and cnt_load_n are never active in the same cycle.
- Counter wrap (e.g. 15->0) is legal in RUN when term_val is not on the path; the controller does not care.

Decomposition:
- Package counter_seq_pkg holds:
  - state encoding constants ST_IDLE, ST_LOAD, ST_RUN, ST_HALT;
  - default DEB_CYCLES and TICK_DIV.
- One sub-module, key_debounce (parameter DEB_CYCLES; ports clk, rst_n, key_n, level, press), instantiated three times.
- FSM, divider and step_count live in counter_sequencer.

Test Plan (bench uses DEB_CYCLES=4, TICK_DIV=4 and a behavioural 4-bit counter driven by cnt_load_n/cnt_data/cnt_step):
1. rst_n low 3 cycles with all keys held pressed -> all outputs at reset values, no press events; 6 cycles after release of rst_n exactly one load event -> cnt_load_n low once.
2. load_val=9, key_load_n pressed 12 cycles -> exactly one cnt_load_n=0 cycle, cnt_data=9, cnt_q=9, step_count=0, state returns to 0.
3. key_step_n with 1-3 cycle bounce glitches, then held 10 cycles -> exactly one cnt_step pulse, cnt_q 9->10, step_count=1.
4. load 3, term_val=7, press run -> cnt_step every 4 cycles, cnt_q 3,4,5,6,7, then state=3, tc=1, step_count=4, no further steps.
5. In RUN, key_load_n and key_run_n released to pressed on the same cycle -> LOAD taken (cnt_load_n low once), state 2->1->0.
6. rst_n low for one cycle during RUN, just before a tick -> no cnt_step emitted, state=0, step_count=0, cnt_data=0.
